frog_position_ctrl: RTL and testbench
=====================================

// Module: frog_position_ctrl
// PURPOSE
//  Upstream stage of vga_controller: turns four raw push-buttons into the frog sprite's top-left pixel position.
//  Debounces buttons, latches one hop request, applies it only on frame_tick (start of vertical blanking) so the sprite never tears.
//  Holds a hop state for HOP_FRAMES frames; frog_x/frog_y feed the sprite compare in the VGA controller.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable samples before a button level is accepted (10 ms @ 25 MHz)
//  STEP             32      pixels moved per hop (= frog size)
//  X_MIN / X_MAX    0 / 608 horizontal bounds of frog_x (640-32)
//  Y_MIN / Y_MAX    0 / 448 vertical bounds of frog_y (480-32)
//  X_START/Y_START  304/448 spawn position
//  HOP_FRAMES       8       frame_ticks spent in HOP after an accepted move (>=1)
// PORTS
//  clk          in   1   pixel clock
//  reset        in   1   asynchronous, active-high
//  btn_up/down/left/right in 1  raw asynchronous buttons, active-high
//  frame_tick   in   1   1-cycle pulse, start of vertical blanking
//  respawn      in   1   1-cycle pulse from collision logic
//  frog_x       out  10  sprite left edge, pixels
//  frog_y       out  10  sprite top edge, pixels
//  hopping      out  1   high while in HOP
//  hop_dir      out  2   direction of last accepted hop: 0 up,1 down,2 left,3 right
// BEHAVIOUR
//  Reset (async): frog_x=X_START, frog_y=Y_START, hopping=0, hop_dir=0, pending clear, sync/debounce flops 0, state IDLE.
//  Input path: 2-flop synchroniser per button; debounced level toggles after DEBOUNCE_CYCLES equal samples differing from it.
//  Request: rising edge of a debounced level sets pending+dir if nothing pending; else ignored.
//   Simultaneous edges: priority up > down > left > right. Falling edges ignored.
//  FSM IDLE: on frame_tick with pending -> compute target in 11-bit unsigned.
//   Target inside bounds -> frog_x/frog_y update on that edge, hop_dir=dir, hop counter=HOP_FRAMES-1, -> HOP.
//   Target outside bounds (e.g. left at x<X_MIN+STEP, up at y<Y_MIN+STEP) -> position unchanged, pending cleared, stay IDLE.
//   No frame_tick -> hold; pending waits.
//  FSM HOP: hopping=1; each frame_tick decrements counter; frame_tick at counter 0 -> IDLE (no move on that tick).
//   Edges arriving in HOP are latched (one pending) and served on the first frame_tick in IDLE.
//  respawn (sync, highest priority, any state): position=start, IDLE, hopping=0, pending cleared; beats a same-cycle frame_tick.
//  Latency: raw press -> pending = 2+DEBOUNCE_CYCLES+1 cycles; pending -> new position 1 cycle after frame_tick edge.
//  Outputs are registered and only change on frame_tick, respawn or reset.
// CONFIGURATION
//  FROG_WRAP_EN defined: horizontal moves wrap, left at X_MIN -> X_MAX, right at X_MAX -> X_MIN; always accepted -> HOP.
//  FROG_WRAP_EN undefined: horizontal moves clamp as above. Vertical always clamps in both builds.
// STRUCTURE
//  Shared header frog_defs.vh: H_VISIBLE 640, V_VISIBLE 480, FROG_SIZE 32, DIR_UP/DOWN/LEFT/RIGHT codes, ST_IDLE/ST_HOP encodings.
//  Sub-module button_debouncer (sync + counter + rising-edge pulse), instantiated 4x; FSM and position math stay in top.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, HOP_FRAMES=2)
//  Reset mid-hop -> frog_x=304, frog_y=448, hopping=0 immediately, no move on next frame_tick.
//  btn_up held 10 cycles, then frame_tick -> frog_y=416, hop_dir=0, hopping=1; hopping=0 after 2 more ticks.
//  btn_up 3-cycle glitch (< debounce) + frame_tick -> frog_y stays 448, hopping=0.
//  btn_up and btn_right rise same cycle -> only up applied (y=416, x=304); right dropped.
//  frog_x=0, press left, frame_tick -> wrap build x=608 hopping=1; clamp build x=0 hopping=0.
//  respawn and frame_tick same cycle with pending down at y=416 -> x=304, y=448, pending cleared, later tick no move.

Source files
------------

// File: rtl/frog_position_ctrl_pkg.sv
// Shared constants, direction/state encodings and request priority for the frog position controller.
// Optional build macro used by the top: FROG_WRAP_EN (horizontal wrap-around instead of clamping).
package frog_position_ctrl_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int FROG_SIZE = 32;

  localparam int DEF_X_MAX   = H_VISIBLE - FROG_SIZE;
  localparam int DEF_Y_MAX   = V_VISIBLE - FROG_SIZE;
  localparam int DEF_X_START = 304;
  localparam int DEF_Y_START = DEF_Y_MAX;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOP  = 1'b1
  } state_e;

  // rise bit order is {right, left, down, up}; lowest index wins
  function automatic dir_e pick_dir(input logic [3:0] rise);
    dir_e d;
    if (rise[0])      d = DIR_UP;
    else if (rise[1]) d = DIR_DOWN;
    else if (rise[2]) d = DIR_LEFT;
    else              d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/frog_position_ctrl_if.sv
// Button/tick inputs and sprite position outputs of the frog controller, bundled as one interface.
interface frog_position_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       frame_tick;
  logic       respawn;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic       hopping;
  logic [1:0] hop_dir;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, frame_tick, respawn,
    input  frog_x, frog_y, hopping, hop_dir
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, frame_tick, respawn,
    output frog_x, frog_y, hopping, hop_dir
  );
endinterface

// File: rtl/frog_position_ctrl_button_debouncer.sv
// One push-button: 2-flop synchroniser, down-counting debounce timer and a registered rising-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Timer counts consecutive samples that disagree with the accepted level;
  // terminal count (0) on a disagreeing sample flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q == '0) begin
      level_d = sync2_q;
      cnt_d   = CNT_LOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= CNT_LOAD;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/frog_position_ctrl.sv
// Frog sprite position controller: debounced buttons -> one pending hop, applied only on frame_tick.
// Build option: define FROG_WRAP_EN to wrap horizontal moves at the screen edges instead of clamping.
//
// state   | meaning
// ST_IDLE | waiting for frame_tick to serve a pending hop request
// ST_HOP  | hop in progress; frame_tick counts down the hop frames
module frog_position_ctrl
  import frog_position_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP            = FROG_SIZE,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = DEF_X_MAX,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = DEF_Y_MAX,
  parameter int X_START         = DEF_X_START,
  parameter int Y_START         = DEF_Y_START,
  parameter int HOP_FRAMES      = 8
) (
  input  logic               clk,
  input  logic               reset,
  frog_position_ctrl_if.slave bus
);

  localparam int HCNT_W = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;
  localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOP_FRAMES - 1);

  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] X_MIN_W = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

  logic [3:0] btn_raw, btn_level, btn_rise;

  assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw[i]),
      .level   (btn_level[i]),
      .rise    (btn_rise[i])
    );
  end

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  dir_e              dir_q, dir_d;
  logic              pend_q, pend_d;
  dir_e              pend_dir_q, pend_dir_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  logic [10:0] x_w, y_w, tgt_x, tgt_y;
  logic        tgt_ok;
  logic        consume;

  assign x_w = {1'b0, x_q};
  assign y_w = {1'b0, y_q};

  // 11-bit math keeps x+STEP / y-STEP free of overflow before the bound check
  always_comb begin
    tgt_x  = x_w;
    tgt_y  = y_w;
    tgt_ok = 1'b1;
    case (pend_dir_q)
      DIR_UP: begin
        if (y_w >= Y_MIN_W + STEP_W) tgt_y = y_w - STEP_W;
        else                         tgt_ok = 1'b0;
      end
      DIR_DOWN: begin
        if (y_w + STEP_W <= Y_MAX_W) tgt_y = y_w + STEP_W;
        else                         tgt_ok = 1'b0;
      end
      DIR_LEFT: begin
        if (x_w >= X_MIN_W + STEP_W) begin
          tgt_x = x_w - STEP_W;
        end else begin
`ifdef FROG_WRAP_EN
          tgt_x = X_MAX_W;
`else
          tgt_ok = 1'b0;
`endif
        end
      end
      default: begin
        if (x_w + STEP_W <= X_MAX_W) begin
          tgt_x = x_w + STEP_W;
        end else begin
`ifdef FROG_WRAP_EN
          tgt_x = X_MIN_W;
`else
          tgt_ok = 1'b0;
`endif
        end
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    hcnt_d     = hcnt_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    consume    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_tick && pend_q) begin
          consume = 1'b1;
          if (tgt_ok) begin
            x_d     = tgt_x[9:0];
            y_d     = tgt_y[9:0];
            dir_d   = pend_dir_q;
            hcnt_d  = HCNT_LOAD;
            state_d = ST_HOP;
          end
        end
      end
      default: begin
        if (bus.frame_tick) begin
          if (hcnt_q == '0) state_d = ST_IDLE;
          else              hcnt_d  = hcnt_q - 1'b1;
        end
      end
    endcase

    if (consume) pend_d = 1'b0;
    // a request served this cycle frees the slot for an edge arriving in the same cycle
    if ((|btn_rise) && (!pend_q || consume)) begin
      pend_d     = 1'b1;
      pend_dir_d = pick_dir(btn_rise);
    end

    if (bus.respawn) begin
      state_d = ST_IDLE;
      x_d     = 10'(X_START);
      y_d     = 10'(Y_START);
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= 10'(X_START);
      y_q        <= 10'(Y_START);
      dir_q      <= DIR_UP;
      pend_q     <= 1'b0;
      pend_dir_q <= DIR_UP;
      hcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      hcnt_q     <= hcnt_d;
    end
  end

  assign bus.frog_x  = x_q;
  assign bus.frog_y  = y_q;
  assign bus.hopping = (state_q == ST_HOP);
  assign bus.hop_dir = dir_q;

endmodule

// File: tb/tb_frog_position_ctrl.sv
// Directed bench for frog_position_ctrl with DEBOUNCE_CYCLES=4, HOP_FRAMES=2; follows FROG_WRAP_EN if defined.
module tb_frog_position_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  frog_position_ctrl_if bus ();

  frog_position_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HOP_FRAMES      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] v);
    bus.btn_up    = v[0];
    bus.btn_down  = v[1];
    bus.btn_left  = v[2];
    bus.btn_right = v[3];
  endtask

  task automatic press(input logic [3:0] v);
    set_btns(v);
    step(10);
    set_btns(4'b0000);
    step(10);
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    total++; if (bus.frog_x !== 10'd304) begin bad++; $display("FAIL reset_x got=%0d exp=304", bus.frog_x); end
    total++; if (bus.frog_y !== 10'd448) begin bad++; $display("FAIL reset_y got=%0d exp=448", bus.frog_y); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL reset_hopping got=%b exp=0", bus.hopping); end
    total++; if (bus.hop_dir !== 2'd0) begin bad++; $display("FAIL reset_dir got=%0d exp=0", bus.hop_dir); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_single_hop();
    press(4'b0001);
    tick();
    total++; if (bus.frog_y !== 10'd416) begin bad++; $display("FAIL hop_y got=%0d exp=416", bus.frog_y); end
    total++; if (bus.frog_x !== 10'd304) begin bad++; $display("FAIL hop_x got=%0d exp=304", bus.frog_x); end
    total++; if (bus.hop_dir !== 2'd0) begin bad++; $display("FAIL hop_dir got=%0d exp=0", bus.hop_dir); end
    total++; if (bus.hopping !== 1'b1) begin bad++; $display("FAIL hop_on got=%b exp=1", bus.hopping); end
    tick();
    total++; if (bus.hopping !== 1'b1) begin bad++; $display("FAIL hop_hold got=%b exp=1", bus.hopping); end
    tick();
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL hop_end got=%b exp=0", bus.hopping); end
    total++; if (bus.frog_y !== 10'd416) begin bad++; $display("FAIL hop_end_y got=%0d exp=416", bus.frog_y); end
  endtask

  task automatic test_reset_mid_hop();
    press(4'b0001);
    tick();
    total++; if (bus.frog_y !== 10'd384) begin bad++; $display("FAIL mid_pre_y got=%0d exp=384", bus.frog_y); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus.frog_x !== 10'd304) begin bad++; $display("FAIL mid_x got=%0d exp=304", bus.frog_x); end
    total++; if (bus.frog_y !== 10'd448) begin bad++; $display("FAIL mid_y got=%0d exp=448", bus.frog_y); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL mid_hopping got=%b exp=0", bus.hopping); end
    step(1);
    reset = 1'b0;
    step(1);
    tick();
    total++; if (bus.frog_y !== 10'd448) begin bad++; $display("FAIL mid_after_y got=%0d exp=448", bus.frog_y); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL mid_after_hopping got=%b exp=0", bus.hopping); end
  endtask

  task automatic test_glitch();
    set_btns(4'b0001);
    step(3);
    set_btns(4'b0000);
    step(12);
    tick();
    total++; if (bus.frog_y !== 10'd448) begin bad++; $display("FAIL glitch_y got=%0d exp=448", bus.frog_y); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL glitch_hopping got=%b exp=0", bus.hopping); end
  endtask

  task automatic test_simultaneous();
    press(4'b1001);
    tick();
    total++; if (bus.frog_y !== 10'd416) begin bad++; $display("FAIL simul_y got=%0d exp=416", bus.frog_y); end
    total++; if (bus.frog_x !== 10'd304) begin bad++; $display("FAIL simul_x got=%0d exp=304", bus.frog_x); end
    total++; if (bus.hop_dir !== 2'd0) begin bad++; $display("FAIL simul_dir got=%0d exp=0", bus.hop_dir); end
    tick();
    tick();
    tick();
    total++; if (bus.frog_x !== 10'd304) begin bad++; $display("FAIL simul_dropped_x got=%0d exp=304", bus.frog_x); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL simul_dropped_hopping got=%b exp=0", bus.hopping); end
  endtask

  task automatic test_respawn_tick();
    press(4'b0001);
    bus.respawn    = 1'b1;
    bus.frame_tick = 1'b1;
    step(1);
    bus.respawn    = 1'b0;
    bus.frame_tick = 1'b0;
    step(1);
    total++; if (bus.frog_x !== 10'd304) begin bad++; $display("FAIL respawn_x got=%0d exp=304", bus.frog_x); end
    total++; if (bus.frog_y !== 10'd448) begin bad++; $display("FAIL respawn_y got=%0d exp=448", bus.frog_y); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL respawn_hopping got=%b exp=0", bus.hopping); end
    tick();
    total++; if (bus.frog_y !== 10'd448) begin bad++; $display("FAIL respawn_cleared_y got=%0d exp=448", bus.frog_y); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL respawn_cleared_hopping got=%b exp=0", bus.hopping); end
  endtask

  task automatic test_clamp_down();
    press(4'b0010);
    tick();
    total++; if (bus.frog_y !== 10'd448) begin bad++; $display("FAIL clamp_down_y got=%0d exp=448", bus.frog_y); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL clamp_down_hopping got=%b exp=0", bus.hopping); end
  endtask

  task automatic test_edge_during_hop();
    press(4'b0001);
    tick();
    total++; if (bus.frog_y !== 10'd416) begin bad++; $display("FAIL inhop_y got=%0d exp=416", bus.frog_y); end
    press(4'b0100);
    tick();
    total++; if (bus.frog_x !== 10'd304) begin bad++; $display("FAIL inhop_hold_x got=%0d exp=304", bus.frog_x); end
    tick();
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL inhop_end_hopping got=%b exp=0", bus.hopping); end
    total++; if (bus.frog_x !== 10'd304) begin bad++; $display("FAIL inhop_end_x got=%0d exp=304", bus.frog_x); end
    tick();
    total++; if (bus.frog_x !== 10'd272) begin bad++; $display("FAIL inhop_served_x got=%0d exp=272", bus.frog_x); end
    total++; if (bus.hop_dir !== 2'd2) begin bad++; $display("FAIL inhop_served_dir got=%0d exp=2", bus.hop_dir); end
    total++; if (bus.hopping !== 1'b1) begin bad++; $display("FAIL inhop_served_hopping got=%b exp=1", bus.hopping); end
    tick();
    tick();
  endtask

  task automatic test_left_edge();
    logic [9:0] exp_x;
    exp_x = 10'd272;
    for (int i = 0; i < 8; i++) begin
      press(4'b0100);
      tick();
      exp_x = exp_x - 10'd32;
      total++; if (bus.frog_x !== exp_x) begin bad++; $display("FAIL left_walk_x step=%0d got=%0d exp=%0d", i, bus.frog_x, exp_x); end
      tick();
      tick();
    end
    press(4'b0100);
    tick();
`ifdef FROG_WRAP_EN
    total++; if (bus.frog_x !== 10'd608) begin bad++; $display("FAIL left_edge_x got=%0d exp=608", bus.frog_x); end
    total++; if (bus.hopping !== 1'b1) begin bad++; $display("FAIL left_edge_hopping got=%b exp=1", bus.hopping); end
`else
    total++; if (bus.frog_x !== 10'd16) begin bad++; $display("FAIL left_edge_x got=%0d exp=16", bus.frog_x); end
    total++; if (bus.hopping !== 1'b0) begin bad++; $display("FAIL left_edge_hopping got=%b exp=0", bus.hopping); end
`endif
    total++; if (bus.frog_y !== 10'd416) begin bad++; $display("FAIL left_edge_y got=%0d exp=416", bus.frog_y); end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.respawn    = 1'b0;
    set_btns(4'b0000);
    test_reset();
    test_single_hop();
    test_reset_mid_hop();
    test_glitch();
    test_simultaneous();
    test_respawn_tick();
    test_clamp_down();
    test_edge_during_hop();
    test_left_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
